alu_issue_sequencer: RTL and testbench
======================================

Name: alu_issue_sequencer

Overview:
- Multi-cycle issue/writeback controller directly upstream of the register-file + ALU datapath.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the register-file read addresses (A1/A2) and the ALU Opcode, captures the ALU Result, and writes it back through WE3/A3/WD3.
- Returns the written value to the requester over a second valid/ready handshake, and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width; matches WD3/Result.
- ADDR_W, 5, register address width; matches A1/A2/A3.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  instruction valid.
- IN_READY  out  1  sequencer can accept an instruction.
- IN_INSTR  in  18  [17]=LI flag, [16:15]=op, [14:10]=rd, [9:5]=rs1, [4:0]=rs2.
- IN_IMM  in  DATA_W  immediate; used only when LI=1.
- A1  out  ADDR_W  register-file read address 1 (rs1).
- A2  out  ADDR_W  register-file read address 2 (rs2).
- OPCODE  out  2  ALU operation code.
- ALU_RESULT  in  DATA_W  ALU result; combinational from A1/A2/OPCODE.
- WE3  out  1  register-file write enable.
- A3  out  ADDR_W  register-file write address.
- WD3  out  DATA_W  register-file write data.
- OUT_VALID  out  1  writeback result available.
- OUT_READY  in  1  consumer accepts the result.
- OUT_DATA  out  DATA_W  value written to rd.
- OUT_RD  out  ADDR_W  destination register of OUT_DATA.
- RETIRED  out  CNT_W  count of completed handshakes on OUT.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE.
  - IN_READY=1; WE3=0; OUT_VALID=0.
  - A1, A2, A3, OPCODE, WD3, OUT_DATA, OUT_RD all 0; RETIRED=0.
- Reset mid-operation aborts immediately: any pending write is dropped, WE3 is forced to 0 asynchronously, and no partial writeback occurs.
- States: IDLE -> EXEC -> WB -> RESP -> IDLE. LI instructions skip EXEC: IDLE -> WB directly.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY, register all instruction fields and IN_IMM.
  - Next state is EXEC if LI=0, WB if LI=1.
  - IN_READY=0 in every other state.
- EXEC (exactly 1 cycle):
  - A1=rs1, A2=rs2, OPCODE=op, held stable for the whole cycle.
  - At the cycle's closing edge, capture ALU_RESULT into the write-data register; next state WB.
  - A1, A2 and OPCODE hold their last values outside EXEC; they do not return to 0.
- WB (exactly 1 cycle):
  - WE3=1, A3=rd, WD3=captured value (IN_IMM for LI).
  - WE3 is registered and high for exactly this one cycle per instruction.
  - Writes to rd=0 are issued like any other address; this block does not special-case register 0.
  - Next state RESP.
- RESP:
  - OUT_VALID=1, OUT_DATA=written value, OUT_RD=rd, all held stable until OUT_READY.
  - On OUT_VALID&OUT_READY: RETIRED increments; next cycle is IDLE with OUT_VALID=0.
  - OUT_VALID must not drop without a handshake, regardless of stalls.
- Latency from input handshake edge:
  - ALU instruction: WE3 high in cycle +2; OUT_VALID in cycle +3.
  - LI instruction: WE3 high in cycle +1; OUT_VALID in cycle +2.
- Throughput: with OUT_READY tied high, one ALU instruction per 4 cycles and one LI per 3 cycles.
  - IN_READY does not rise in the same cycle as the OUT handshake; it is registered, so there is no combinational IN/OUT path.
- Read-after-write: the next instruction's EXEC always follows the previous WB edge, so a dependent instruction reads the updated register. No forwarding is required.
- RETIRED wraps from 2^CNT_W-1 to 0 silently.
- IN_VALID while IN_READY=0 is ignored; the instruction fields are not sampled.

Test Plan:
1. Reset: hold RST_N=0 with IN_VALID=1 -> IN_READY=1, WE3=0, OUT_VALID=0, RETIRED=0 throughout; no state advance.
2. LI then ALU:
   - Stimulus: LI rd=1 imm=5; LI rd=2 imm=7; op=00 rd=3 rs1=1 rs2=2. Bench ALU model: 00 = A+B.
   - Required: WE3 pulses with (A3,WD3) = (1,5), (2,7), (3,12). OUT_DATA sequence 5, 7, 12. RETIRED=3.
3. Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID -> OUT_VALID, OUT_DATA, OUT_RD stable; IN_READY=0; WE3 pulses only once; RETIRED increments by 1 on release.
4. Dependency: op=00 rd=1 rs1=1 rs2=1 issued back-to-back three times with r1=1 -> written values 2, 4, 8.
5. Reset mid-EXEC: assert RST_N=0 during EXEC -> WE3 is never asserted, OUT_VALID=0, and the destination register keeps its old value.
6. Counter wrap: CNT_W=2, retire 5 instructions -> RETIRED sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// Issue/writeback sequencer in front of a register file and ALU: takes one
// instruction, drives the read ports and opcode, writes the result back, and returns it.
module alu_issue_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [17:0]       IN_INSTR,
  input  logic [DATA_W-1:0] IN_IMM,
  output logic [ADDR_W-1:0] A1,
  output logic [ADDR_W-1:0] A2,
  output logic [1:0]        OPCODE,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [ADDR_W-1:0] OUT_RD,
  output logic [CNT_W-1:0]  RETIRED
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic [ADDR_W-1:0]   a1_q, a2_q, a3_q, out_rd_q;
  logic [1:0]          op_q;
  logic                we3_q;
  logic [DATA_W-1:0]   wd3_q, out_data_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    retired_q;
  logic [CNT_W-1:0]    retired_d;

  logic                instr_li;
  logic [1:0]          instr_op;
  logic [ADDR_W-1:0]   instr_rd, instr_rs1, instr_rs2;

  assign instr_li  = IN_INSTR[17];
  assign instr_op  = IN_INSTR[16:15];
  assign instr_rd  = ADDR_W'(IN_INSTR[14:10]);
  assign instr_rs1 = ADDR_W'(IN_INSTR[9:5]);
  assign instr_rs2 = ADDR_W'(IN_INSTR[4:0]);

  // Counter wraps naturally at 2^CNT_W.
  assign retired_d = retired_q + CNT_W'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      a1_q        <= '0;
      a2_q        <= '0;
      op_q        <= '0;
      we3_q       <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      retired_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID && in_ready_q) begin
            in_ready_q <= 1'b0;
            a3_q       <= instr_rd;
            if (instr_li) begin
              wd3_q   <= IN_IMM;
              we3_q   <= 1'b1;
              state_q <= WB;
            end else begin
              // Read ports only move for ALU ops, so they stay put across LI.
              a1_q    <= instr_rs1;
              a2_q    <= instr_rs2;
              op_q    <= instr_op;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          wd3_q   <= ALU_RESULT;
          we3_q   <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          we3_q       <= 1'b0;
          out_valid_q <= 1'b1;
          out_data_q  <= wd3_q;
          out_rd_q    <= a3_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            retired_q   <= retired_d;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          we3_q      <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign A1        = a1_q;
  assign A2        = a2_q;
  assign OPCODE    = op_q;
  assign WE3       = we3_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_RD    = out_rd_q;
  assign RETIRED   = retired_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_issue_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic              IN_VALID = 1'b0;
  logic              OUT_READY = 1'b1;
  logic [17:0]       IN_INSTR = '0;
  logic [DATA_W-1:0] IN_IMM = '0;

  logic              ir [2];
  logic              we [2];
  logic              ov [2];
  logic [ADDR_W-1:0] a1 [2];
  logic [ADDR_W-1:0] a2 [2];
  logic [ADDR_W-1:0] a3 [2];
  logic [ADDR_W-1:0] ord [2];
  logic [1:0]        opc [2];
  logic [DATA_W-1:0] wd [2];
  logic [DATA_W-1:0] od [2];
  logic [DATA_W-1:0] alu [2];
  logic [15:0]       ret0;
  logic [1:0]        ret1;

  logic [DATA_W-1:0] rf [32];

  function automatic logic [DATA_W-1:0] alu_f(input logic [1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu[0] = alu_f(opc[0], rf[a1[0]], rf[a2[0]]);
  assign alu[1] = alu_f(opc[1], rf[a1[1]], rf[a2[1]]);

  alu_issue_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) u0 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir[0]),
    .IN_INSTR(IN_INSTR), .IN_IMM(IN_IMM), .A1(a1[0]), .A2(a2[0]),
    .OPCODE(opc[0]), .ALU_RESULT(alu[0]), .WE3(we[0]), .A3(a3[0]), .WD3(wd[0]),
    .OUT_VALID(ov[0]), .OUT_READY(OUT_READY), .OUT_DATA(od[0]), .OUT_RD(ord[0]),
    .RETIRED(ret0));

  alu_issue_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2)) u1 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(ir[1]),
    .IN_INSTR(IN_INSTR), .IN_IMM(IN_IMM), .A1(a1[1]), .A2(a2[1]),
    .OPCODE(opc[1]), .ALU_RESULT(alu[1]), .WE3(we[1]), .A3(a3[1]), .WD3(wd[1]),
    .OUT_VALID(ov[1]), .OUT_READY(OUT_READY), .OUT_DATA(od[1]), .OUT_RD(ord[1]),
    .RETIRED(ret1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  // Transaction model: one instruction in flight, tracked by its age in cycles.
  bit                m_act = 1'b0;
  int                m_age = 0;
  bit                m_li = 1'b0;
  logic [4:0]        m_rd = '0;
  logic [DATA_W-1:0] m_val = '0;
  logic [4:0]        m_a1 = '0, m_a2 = '0;
  logic [1:0]        m_opc = '0;
  int unsigned       m_ret = 0;
  logic [DATA_W-1:0] m_rf [32];

  function automatic int wb_age(input bit li);
    return li ? 1 : 2;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_act = 1'b0; m_age = 0; m_ret = 0;
      m_a1 = '0; m_a2 = '0; m_opc = '0;
    end else if (m_act) begin
      if (m_age > wb_age(m_li) && OUT_READY) begin
        m_act = 1'b0;
        m_ret++;
      end else begin
        m_age++;
        if (m_age == wb_age(m_li)) m_rf[m_rd] = m_val;
      end
    end else if (IN_VALID) begin
      m_act = 1'b1;
      m_age = 1;
      m_li  = IN_INSTR[17];
      m_rd  = IN_INSTR[14:10];
      if (m_li) begin
        m_val = IN_IMM;
        m_rf[m_rd] = m_val;
      end else begin
        m_a1  = IN_INSTR[9:5];
        m_a2  = IN_INSTR[4:0];
        m_opc = IN_INSTR[16:15];
        m_val = alu_f(m_opc, m_rf[m_a1], m_rf[m_a2]);
      end
    end
  end

  bit e_ir, e_we, e_ov;
  always @(negedge CLK) begin
    e_ir = !m_act;
    e_we = m_act && (m_age == wb_age(m_li));
    e_ov = m_act && (m_age > wb_age(m_li));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.in_ready", i), 64'(ir[i]), 64'(e_ir));
      chk($sformatf("u%0d.we3", i), 64'(we[i]), 64'(e_we));
      chk($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(e_ov));
      chk($sformatf("u%0d.a1", i), 64'(a1[i]), 64'(m_a1));
      chk($sformatf("u%0d.a2", i), 64'(a2[i]), 64'(m_a2));
      chk($sformatf("u%0d.opcode", i), 64'(opc[i]), 64'(m_opc));
      if (e_we) begin
        chk($sformatf("u%0d.a3", i), 64'(a3[i]), 64'(m_rd));
        chk($sformatf("u%0d.wd3", i), 64'(wd[i]), 64'(m_val));
      end
      if (e_ov) begin
        chk($sformatf("u%0d.out_data", i), 64'(od[i]), 64'(m_val));
        chk($sformatf("u%0d.out_rd", i), 64'(ord[i]), 64'(m_rd));
      end
      if (!RST_N) begin
        chk($sformatf("u%0d.rst_a3", i), 64'(a3[i]), 64'(0));
        chk($sformatf("u%0d.rst_wd3", i), 64'(wd[i]), 64'(0));
        chk($sformatf("u%0d.rst_out_data", i), 64'(od[i]), 64'(0));
        chk($sformatf("u%0d.rst_out_rd", i), 64'(ord[i]), 64'(0));
      end
    end
    chk("u0.retired", 64'(ret0), 64'(m_ret[15:0]));
    chk("u1.retired", 64'(ret1), 64'(m_ret[1:0]));
  end

  // Register file and event recorders driven by u0.
  int                we_cnt = 0;
  bit                hs_flag = 1'b0;
  bit                rec_ret = 1'b0;
  logic [ADDR_W-1:0] wa_q [$];
  logic [DATA_W-1:0] wv_q [$];
  logic [DATA_W-1:0] out_q [$];
  logic [1:0]        ret_q [$];

  always @(posedge CLK) begin
    if (RST_N) begin
      if (we[0]) begin
        rf[a3[0]] = wd[0];
        we_cnt++;
        wa_q.push_back(a3[0]);
        wv_q.push_back(wd[0]);
      end
      if (ov[0] && OUT_READY) begin
        out_q.push_back(od[0]);
        hs_flag = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (hs_flag) begin
      hs_flag = 1'b0;
      if (rec_ret) ret_q.push_back(ret1);
    end
  end

  task automatic issue(input bit li, input logic [1:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [DATA_W-1:0] imm);
    int n;
    @(negedge CLK);
    IN_INSTR = {li, op, rd, rs1, rs2};
    IN_IMM   = imm;
    IN_VALID = 1'b1;
    n = 0;
    while (!ir[0] && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) timeout_fail("issue_wait_ready");
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ir[0] && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) timeout_fail("wait_idle");
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  int n_wait;
  int we_before;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      m_rf[i] = '0;
    end

    // Reset held with a valid instruction offered: nothing may advance.
    IN_VALID = 1'b1;
    IN_INSTR = {1'b1, 2'd0, 5'd3, 5'd0, 5'd0};
    IN_IMM   = 32'hDEAD;
    repeat (5) begin
      @(negedge CLK);
      chk("rst_in_ready", 64'(ir[0]), 64'(1));
      chk("rst_we3", 64'(we[0]), 64'(0));
      chk("rst_out_valid", 64'(ov[0]), 64'(0));
      chk("rst_retired", 64'(ret0), 64'(0));
    end
    IN_VALID = 1'b0;
    RST_N = 1'b1;

    // LI, LI, then ADD using both.
    wa_q.delete(); wv_q.delete(); out_q.delete();
    issue(1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    issue(1'b1, 2'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    issue(1'b0, 2'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    wait_idle();
    chk("t2_nwrites", 64'(wa_q.size()), 64'(3));
    chk("t2_nouts", 64'(out_q.size()), 64'(3));
    if (wa_q.size() == 3 && out_q.size() == 3) begin
      chk("t2_w0", {27'd0, wa_q[0], wv_q[0]}, {27'd0, 5'd1, 32'd5});
      chk("t2_w1", {27'd0, wa_q[1], wv_q[1]}, {27'd0, 5'd2, 32'd7});
      chk("t2_w2", {27'd0, wa_q[2], wv_q[2]}, {27'd0, 5'd3, 32'd12});
      chk("t2_o0", 64'(out_q[0]), 64'(5));
      chk("t2_o1", 64'(out_q[1]), 64'(7));
      chk("t2_o2", 64'(out_q[2]), 64'(12));
    end
    chk("t2_retired", 64'(ret0), 64'(3));

    // Backpressure for 10 cycles.
    OUT_READY = 1'b0;
    we_cnt = 0;
    issue(1'b1, 2'd0, 5'd4, 5'd0, 5'd0, 32'hABCD);
    n_wait = 0;
    while (!ov[0] && n_wait < 20) begin
      @(negedge CLK);
      n_wait++;
    end
    if (n_wait >= 20) timeout_fail("t3_wait_out_valid");
    repeat (10) begin
      @(negedge CLK);
      chk("t3_out_valid", 64'(ov[0]), 64'(1));
      chk("t3_out_data", 64'(od[0]), 64'(32'hABCD));
      chk("t3_out_rd", 64'(ord[0]), 64'(4));
      chk("t3_in_ready", 64'(ir[0]), 64'(0));
    end
    chk("t3_we_pulses", 64'(we_cnt), 64'(1));
    OUT_READY = 1'b1;
    @(negedge CLK);
    wait_idle();
    chk("t3_retired", 64'(ret0), 64'(4));

    // Dependent chain r1 = r1 + r1.
    out_q.delete();
    issue(1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    repeat (3) issue(1'b0, 2'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    wait_idle();
    chk("t4_nouts", 64'(out_q.size()), 64'(4));
    if (out_q.size() == 4) begin
      chk("t4_o1", 64'(out_q[1]), 64'(2));
      chk("t4_o2", 64'(out_q[2]), 64'(4));
      chk("t4_o3", 64'(out_q[3]), 64'(8));
    end
    chk("t4_retired", 64'(ret0), 64'(8));

    // Reset while the ALU op is in EXEC.
    issue(1'b1, 2'd0, 5'd9, 5'd0, 5'd0, 32'h55);
    wait_idle();
    @(negedge CLK);
    IN_INSTR = {1'b0, 2'd0, 5'd9, 5'd9, 5'd9};
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("t5_in_exec_a1", 64'(a1[0]), 64'(9));
    we_before = we_cnt;
    #1 RST_N = 1'b0;
    #1;
    chk("t5_we3_async", 64'(we[0]), 64'(0));
    chk("t5_out_valid", 64'(ov[0]), 64'(0));
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("t5_no_write", 64'(we_cnt - we_before), 64'(0));
    chk("t5_r9_kept", 64'(rf[9]), 64'(32'h55));
    chk("t5_retired", 64'(ret0), 64'(0));

    // Two-bit counter wrap on u1.
    do_reset();
    ret_q.delete();
    rec_ret = 1'b1;
    for (int i = 0; i < 5; i++) issue(1'b1, 2'd0, 5'(10 + i), 5'd0, 5'd0, 32'(i));
    wait_idle();
    @(negedge CLK);
    rec_ret = 1'b0;
    chk("t6_n", 64'(ret_q.size()), 64'(5));
    if (ret_q.size() == 5) begin
      chk("t6_r0", 64'(ret_q[0]), 64'(1));
      chk("t6_r1", 64'(ret_q[1]), 64'(2));
      chk("t6_r2", 64'(ret_q[2]), 64'(3));
      chk("t6_r3", 64'(ret_q[3]), 64'(0));
      chk("t6_r4", 64'(ret_q[4]), 64'(1));
    end

    // Randomized traffic with random stalls on both sides.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      IN_VALID  = ($urandom_range(0, 2) != 0);
      IN_INSTR  = {($urandom_range(0, 2) == 0), 2'($urandom), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      IN_IMM    = $urandom;
      OUT_READY = ($urandom_range(0, 3) != 0);
    end
    @(negedge CLK);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    wait_idle();
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
